// File: rtl/crop_pkg.sv
// Shared defaults and FSM encoding for the crop streamer.
// Optional row/frame markers are enabled by defining CROP_STREAM_EOL_EN.
package crop_pkg;

    localparam int IMG_W_DEF      = 32;
    localparam int IMG_H_DEF      = 32;
    localparam int PIX_W_DEF      = 8;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of marker bits carried alongside each pixel through the buffer.
    function automatic int side_bits();
`ifdef CROP_STREAM_EOL_EN
        return 2;
`else
        return 0;
`endif
    endfunction

endpackage

// File: rtl/crop_stream_if.sv
// Pixel stream interface (valid/ready); eol/eof present only with CROP_STREAM_EOL_EN.
interface crop_stream_if #(
    parameter int PIX_W = crop_pkg::PIX_W_DEF
) ();

    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
`ifdef CROP_STREAM_EOL_EN
    logic             out_eol;
    logic             out_eof;

    modport master (output out_valid, output out_data, output out_eol, output out_eof,
                    input out_ready);
    modport slave  (input out_valid, input out_data, input out_eol, input out_eof,
                    output out_ready);
`else
    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
`endif

endinterface

// File: rtl/crop_stream_out_pix_buf_2.sv
// Two-entry synchronous FIFO with occupancy count; word carries pixel plus any marker bits.
module pix_buf_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         push_en;
    logic         pop_en;

    // Guard against misuse even though the issuer never over/underflows the buffer.
    assign push_en = push && (count_reg != 2'd2 || pop);
    assign pop_en  = pop && (count_reg != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/crop_stream_out.sv
// Streams an IMG_W x IMG_H crop from a 1-cycle-latency memory out through a valid/ready port.
// Define CROP_STREAM_EOL_EN to add out_eol/out_eof markers.
module crop_stream_out
    import crop_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ce_mem,
    output logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic [PIX_W-1:0]      rd_data,
    crop_stream_if.master         stream
);

    localparam int                  NPIX      = IMG_W * IMG_H;
    localparam int                  BUF_W     = PIX_W + side_bits();
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  inflight_reg;
    logic                  done_reg;

    logic [BUF_W-1:0]      buf_din;
    logic [BUF_W-1:0]      buf_dout;
    logic [1:0]            buf_count;
    logic                  pop;
    logic [2:0]            occ;
    logic                  issue;
    logic                  last_issue;
    logic                  last_hs;

    // Occupancy after this cycle's pop, counting the read whose data lands next edge.
    assign pop        = stream.out_valid && stream.out_ready;
    assign occ        = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue      = (state_reg == RUN) && (occ < 3'd2);
    assign last_issue = issue && (addr_reg == LAST_ADDR);
    assign last_hs    = (state_reg == DRAIN) && pop && (buf_count == 2'd1) && !inflight_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_hs)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        ce_mem   = issue;
        addr_mem = addr_reg;
        done     = done_reg;
    end

    // Address holds at the last location until the frame fully drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg     <= '0;
            inflight_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            inflight_reg <= issue;
            done_reg     <= last_hs;
            if (last_hs) begin
                addr_reg <= '0;
            end else if (issue && !last_issue) begin
                addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef CROP_STREAM_EOL_EN
    logic [ADDR_WIDTH-1:0] col_reg;
    logic                  eol_reg;
    logic                  eof_reg;

    // Markers are computed at issue time and travel with the read into the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            eol_reg <= 1'b0;
            eof_reg <= 1'b0;
        end else begin
            if (issue) begin
                eol_reg <= (col_reg == ADDR_WIDTH'(IMG_W - 1));
                eof_reg <= (addr_reg == LAST_ADDR);
            end
            if (last_hs) begin
                col_reg <= '0;
            end else if (issue) begin
                col_reg <= (col_reg == ADDR_WIDTH'(IMG_W - 1)) ? '0 : col_reg + ADDR_WIDTH'(1);
            end
        end
    end

    assign buf_din        = {eol_reg, eof_reg, rd_data};
    assign stream.out_eol = stream.out_valid && buf_dout[PIX_W+1];
    assign stream.out_eof = stream.out_valid && buf_dout[PIX_W];
`else
    assign buf_din = rd_data;
`endif

    pix_buf_2 #(
        .W (BUF_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_reg),
        .din   (buf_din),
        .pop   (pop),
        .dout  (buf_dout),
        .count (buf_count)
    );

    assign stream.out_valid = (buf_count != 2'd0);
    assign stream.out_data  = buf_dout[PIX_W-1:0];

endmodule

// File: tb/tb_crop_stream_out.sv
// Directed bench for crop_stream_out: timing, backpressure, reset abort, start handling.
// Marker checks are compiled in when CROP_STREAM_EOL_EN is defined.
module tb_crop_stream_out;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int AW    = 10;
    localparam int PW    = 8;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          ce_mem;
    logic [AW-1:0] addr_mem;
    logic [PW-1:0] rd_data;
    logic          ready = 1'b0;

    crop_stream_if #(.PIX_W(PW)) stream ();

    crop_stream_out #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_WIDTH (AW),
        .PIX_W      (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ce_mem   (ce_mem),
        .addr_mem (addr_mem),
        .rd_data  (rd_data),
        .stream   (stream)
    );

    assign stream.out_ready = ready;

    always #5 clk = ~clk;

    logic [PW-1:0] mem [NPIX];
    always @(posedge clk) begin
        if (ce_mem) rd_data <= mem[addr_mem];
    end

    int n_cmp = 0;
    int n_err = 0;

    int cyc, ce_cnt, deliv, first_ce, first_valid, done_cyc, max_diff, eol_cnt, eof_cnt;
    bit prev_stall;
    logic [PW-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: stall cycles 3..22; 3: ready high + start pulses at 5/200.
    task automatic run_frame(input bit issue_start, input int mode, input bit chain, input int abort_at);
        if (issue_start) start = 1'b1;
        cyc = 0; ce_cnt = 0; deliv = 0; first_ce = 0; first_valid = 0; done_cyc = 0;
        max_diff = 0; eol_cnt = 0; eof_cnt = 0; prev_stall = 1'b0; prev_data = '0;
        while (done_cyc == 0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (mode == 3) && (cyc == 5 || cyc == 200);
            case (mode)
                1:       ready = 1'($urandom_range(0, 1));
                2:       ready = !(cyc >= 3 && cyc < 23);
                default: ready = 1'b1;
            endcase
            #1;
            if (prev_stall) begin
                check("stall_valid", 32'(stream.out_valid), 32'd1);
                check("stall_data", 32'(stream.out_data), 32'(prev_data));
            end
            if (ce_mem) begin
                if (first_ce == 0) first_ce = cyc;
                check("addr", 32'(addr_mem), 32'(ce_cnt));
                ce_cnt++;
            end
            if (stream.out_valid && first_valid == 0) first_valid = cyc;
            if (stream.out_valid && ready) begin
                check("pixel", 32'(stream.out_data), 32'(deliv % 256));
`ifdef CROP_STREAM_EOL_EN
                check("eol", 32'(stream.out_eol), 32'(deliv % IMG_W == IMG_W - 1));
                check("eof", 32'(stream.out_eof), 32'(deliv == NPIX - 1));
                if (stream.out_eol) eol_cnt++;
                if (stream.out_eof) eof_cnt++;
`endif
                deliv++;
            end
            if (ce_cnt - deliv > max_diff) max_diff = ce_cnt - deliv;
            prev_stall = stream.out_valid && !ready;
            prev_data  = stream.out_data;
            if (done) begin
                done_cyc = cyc;
                if (chain) start = 1'b1;
            end
            if (abort_at > 0 && deliv == abort_at) break;
        end
        $display("frame mode=%0d: reads=%0d pixels=%0d first_ce=%0d first_valid=%0d done=%0d",
                 mode, ce_cnt, deliv, first_ce, first_valid, done_cyc);
    endtask

    task automatic check_full_frame(input string tag, input int exp_done);
        check({tag, "_done_seen"}, 32'(done_cyc != 0), 32'd1);
        check({tag, "_pixels"}, 32'(deliv), 32'(NPIX));
        check({tag, "_reads"}, 32'(ce_cnt), 32'(NPIX));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (exp_done > 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
`ifdef CROP_STREAM_EOL_EN
        check({tag, "_eol_count"}, 32'(eol_cnt), 32'(IMG_H));
        check({tag, "_eof_count"}, 32'(eof_cnt), 32'd1);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ce_mem"}, 32'(ce_mem), 32'd0);
        check({tag, "_addr_mem"}, 32'(addr_mem), 32'd0);
        check({tag, "_out_valid"}, 32'(stream.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(stream.out_data), 32'd0);
`ifdef CROP_STREAM_EOL_EN
        check({tag, "_out_eol"}, 32'(stream.out_eol), 32'd0);
        check({tag, "_out_eof"}, 32'(stream.out_eof), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = PW'(i % 256);

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Full-rate frame: first read cycle 1, first valid cycle 3, done cycle 1027.
        run_frame(1'b1, 0, 1'b0, 0);
        check_full_frame("rate", 1027);
        check("rate_first_ce", 32'(first_ce), 32'd1);
        check("rate_first_valid", 32'(first_valid), 32'd3);
        check("rate_max_ahead", 32'(max_diff), 32'd2);
        @(posedge clk);
        #2;
        check("rate_done_pulse", 32'(done), 32'd0);
        check("rate_idle_busy", 32'(busy), 32'd0);

        // Random backpressure.
        run_frame(1'b1, 1, 1'b0, 0);
        check_full_frame("random", 0);
        check("random_max_ahead", 32'(max_diff), 32'd2);

        // 20-cycle stall from the first valid: 2 reads ahead, then everything shifts by 20.
        run_frame(1'b1, 2, 1'b0, 0);
        check_full_frame("stall", 1047);
        check("stall_max_ahead", 32'(max_diff), 32'd2);

        // Abort at pixel 500 with an asynchronous reset.
        run_frame(1'b1, 0, 1'b0, 500);
        check("abort_reached", 32'(deliv), 32'd500);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort_rst");
        @(posedge clk);
        #1;
        check_outputs_zero("abort_hold");
        rst = 1'b0;
        run_frame(1'b1, 0, 1'b0, 0);
        check_full_frame("restart", 1027);
        check("restart_first_ce", 32'(first_ce), 32'd1);

        // Mid-frame starts ignored; start coincident with done launches the next frame.
        run_frame(1'b1, 3, 1'b1, 0);
        check_full_frame("ignore", 1027);
        run_frame(1'b0, 0, 1'b0, 0);
        check_full_frame("chain", 1027);
        check("chain_first_ce", 32'(first_ce), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #2;
            check("after_busy", 32'(busy), 32'd0);
            check("after_ce", 32'(ce_mem), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
